// File: rtl/rsa_pkg.sv
// rsa_pkg: types and widths shared by the RSA modular-exponentiation sequencer
// and its divider-port helper.
//   state_e    : top-level sequencer states
//   op_e       : which reduction is in flight (pre-reduce base, square, multiply)
//   dp_state_e : divider-port launch/capture phases
package rsa_pkg;

  localparam int RSA_W     = 512;
  localparam int RSA_EXP_W = 512;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CHECK, ST_PRE, ST_MUL, ST_DSTART, ST_DWAIT, ST_UPDATE, ST_FIN
  } state_e;

  typedef enum logic [1:0] {
    OP_PRE, OP_SQ, OP_ML
  } op_e;

  typedef enum logic [1:0] {
    DP_IDLE, DP_START, DP_WAIT
  } dp_state_e;

endpackage

// File: rtl/div_port_ctrl.sv
// div_port_ctrl: launch-and-capture handshake for a shared start/done divider.
//   ld / ld_dividend / ld_divisor : load operands and launch (accepted when idle)
//   cap / rem                     : cap pulses for one cycle when the remainder
//                                   is captured; rem holds it afterwards
//   div_start/div_dividend/div_divisor/div_rem/div_done : divider interface
// Operands stay registered (stable) from the launch cycle until the next load.
module div_port_ctrl
  import rsa_pkg::*;
#(
  parameter int W  = RSA_W,
  parameter int DW = 2 * W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld,
  input  logic [DW-1:0] ld_dividend,
  input  logic [DW-1:0] ld_divisor,
  output logic          cap,
  output logic [W-1:0]  rem,
  output logic          div_start,
  output logic [DW-1:0] div_dividend,
  output logic [DW-1:0] div_divisor,
  input  logic [DW-1:0] div_rem,
  input  logic          div_done
);

  dp_state_e     ph_q, ph_d;
  logic          div_start_q, div_start_d;
  logic [DW-1:0] dividend_q, dividend_d;
  logic [DW-1:0] divisor_q, divisor_d;
  logic [W-1:0]  rem_q, rem_d;

  // Remainders are always < divisor < 2^W; the upper half is never needed.
  logic unused_rem_hi;
  assign unused_rem_hi = ^div_rem[DW-1:W];

  always_comb begin
    ph_d        = ph_q;
    div_start_d = 1'b0;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    rem_d       = rem_q;
    cap         = 1'b0;
    case (ph_q)
      DP_IDLE: if (ld) begin
        dividend_d  = ld_dividend;
        divisor_d   = ld_divisor;
        div_start_d = 1'b1;
        ph_d        = DP_START;
      end
      // A done level seen while start is high belongs to the previous op.
      DP_START: ph_d = DP_WAIT;
      DP_WAIT: if (div_done) begin
        rem_d = div_rem[W-1:0];
        cap   = 1'b1;
        ph_d  = DP_IDLE;
      end
      default: ph_d = DP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q        <= DP_IDLE;
      div_start_q <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
    end else begin
      ph_q        <= ph_d;
      div_start_q <= div_start_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      rem_q       <= rem_d;
    end
  end

  assign div_start    = div_start_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign rem          = rem_q;

endmodule

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: left-to-right square-and-multiply sequencer computing
// result = base^exp mod modulus, using an external multiplier (mul_a/mul_b ->
// mul_p) and an external divider for every reduction.
//   start/base/exp/modulus : request, operands latched when accepted in idle
//   busy/done/err/result   : status; done pulses one cycle with result/err valid
//   mul_a/mul_b/mul_p      : multiplier operands and combinational product
//   div_*                  : divider launch/capture interface (divider width 2W)
module modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int W     = RSA_W,
  parameter int EXP_W = RSA_EXP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     base,
  input  logic [EXP_W-1:0] exp,
  input  logic [W-1:0]     modulus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [W-1:0]     result,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic [2*W-1:0]   mul_p,
  output logic             div_start,
  output logic [2*W-1:0]   div_dividend,
  output logic [2*W-1:0]   div_divisor,
  input  logic [2*W-1:0]   div_rem,
  input  logic             div_done
);

  localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(EXP_W - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [W-1:0]     base_q, base_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [W-1:0]     n_q, n_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     bred_q, bred_d;
  logic [W-1:0]     result_q, result_d;
  logic [W-1:0]     mul_a_q, mul_a_d;
  logic [W-1:0]     mul_b_q, mul_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             ld;
  logic [2*W-1:0]   ld_dividend;
  logic             cap;
  logic [W-1:0]     rem;
  logic             advance;

  div_port_ctrl #(.W(W)) u_div_port (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld           (ld),
    .ld_dividend  (ld_dividend),
    .ld_divisor   ({{W{1'b0}}, n_q}),
    .cap          (cap),
    .rem          (rem),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_rem      (div_rem),
    .div_done     (div_done)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    idx_d       = idx_q;
    base_d      = base_q;
    exp_d       = exp_q;
    n_d         = n_q;
    acc_d       = acc_q;
    bred_d      = bred_q;
    result_d    = result_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    ld          = 1'b0;
    ld_dividend = '0;
    advance     = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        base_d  = base;
        exp_d   = exp;
        n_d     = modulus;
        acc_d   = W'(1);
        idx_d   = IDX_TOP;
        err_d   = 1'b0;
        busy_d  = 1'b1;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (n_q == '0) begin
          err_d    = 1'b1;
          result_d = '0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_FIN;
        end else begin
          // Base may exceed N; reduce it once before it is used as a factor.
          ld          = 1'b1;
          ld_dividend = {{W{1'b0}}, base_q};
          op_d        = OP_PRE;
          state_d     = ST_DSTART;
        end
      end
      ST_MUL: begin
        ld          = 1'b1;
        ld_dividend = mul_p;
        state_d     = ST_DSTART;
      end
      ST_DSTART: state_d = ST_DWAIT;
      ST_DWAIT:  if (cap) state_d = ST_UPDATE;
      ST_UPDATE: begin
        case (op_q)
          OP_PRE: begin
            bred_d  = rem;
            op_d    = OP_SQ;
            mul_a_d = acc_q;
            mul_b_d = acc_q;
            state_d = ST_MUL;
          end
          OP_SQ: begin
            acc_d = rem;
            if (exp_q[idx_q]) begin
              op_d    = OP_ML;
              mul_a_d = rem;
              mul_b_d = bred_q;
              state_d = ST_MUL;
            end else begin
              advance = 1'b1;
            end
          end
          default: begin
            acc_d   = rem;
            advance = 1'b1;
          end
        endcase
        if (advance) begin
          if (idx_q == '0) begin
            result_d = rem;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_FIN;
          end else begin
            idx_d   = idx_q - 1'b1;
            op_d    = OP_SQ;
            mul_a_d = rem;
            mul_b_d = rem;
            state_d = ST_MUL;
          end
        end
      end
      // done is high in FIN, so a start presented with done is not seen in IDLE.
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_PRE;
      idx_q    <= IDX_TOP;
      base_q   <= '0;
      exp_q    <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      bred_q   <= '0;
      result_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      bred_q   <= bred_d;
      result_q <= result_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
  assign mul_a  = mul_a_q;
  assign mul_b  = mul_b_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: a W=16 instance against a random-latency divider and
// a full-width instance for one large case, both checked against a
// right-to-left modular exponentiation model.
module tb_modexp_ctrl;

  localparam int W  = 16;
  localparam int EW = 16;
  localparam int BW = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- small instance ----------------
  logic            start;
  logic [W-1:0]    base, modulus, result, mul_a, mul_b;
  logic [EW-1:0]   exp;
  logic            busy, done, err, div_start, div_done;
  logic [2*W-1:0]  mul_p, div_dividend, div_divisor, div_rem;

  assign mul_p = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};

  modexp_ctrl #(.W(W), .EXP_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .exp(exp),
    .modulus(modulus), .busy(busy), .done(done), .err(err), .result(result),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_rem(div_rem), .div_done(div_done)
  );

  // Behavioural divider: random 3..40 cycle latency; done either pulses or
  // (hold_done) stays high until the next launch.
  bit             hold_done = 1'b0;
  int             n_starts = 0;
  int             stable_err = 0;
  int             cnt;
  bit             dbusy;
  logic [2*W-1:0] lat_dividend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbusy <= 1'b0; div_done <= 1'b0; div_rem <= '0; cnt <= 0;
    end else if (div_start) begin
      dbusy        <= 1'b1;
      cnt          <= $urandom_range(3, 40) - 1;
      div_done     <= 1'b0;
      lat_dividend <= div_dividend;
      div_rem      <= div_dividend % div_divisor;
      n_starts     <= n_starts + 1;
    end else if (dbusy) begin
      if (div_dividend !== lat_dividend) stable_err <= stable_err + 1;
      if (cnt == 0) begin dbusy <= 1'b0; div_done <= 1'b1; end
      else cnt <= cnt - 1;
    end else if (!hold_done) begin
      div_done <= 1'b0;
    end
  end

  // ---------------- full-width instance ----------------
  logic            w_start, w_busy, w_done, w_err, w_div_start, w_div_done;
  logic [BW-1:0]   w_base, w_exp, w_mod, w_result, w_mul_a, w_mul_b;
  logic [2*BW-1:0] w_mul_p, w_div_dividend, w_div_divisor, w_div_rem;
  int              w_cnt;
  bit              w_dbusy;

  assign w_mul_p = {{BW{1'b0}}, w_mul_a} * {{BW{1'b0}}, w_mul_b};

  modexp_ctrl dut_w (
    .clk(clk), .rst_n(rst_n), .start(w_start), .base(w_base), .exp(w_exp),
    .modulus(w_mod), .busy(w_busy), .done(w_done), .err(w_err),
    .result(w_result), .mul_a(w_mul_a), .mul_b(w_mul_b), .mul_p(w_mul_p),
    .div_start(w_div_start), .div_dividend(w_div_dividend),
    .div_divisor(w_div_divisor), .div_rem(w_div_rem), .div_done(w_div_done)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_dbusy <= 1'b0; w_div_done <= 1'b0; w_div_rem <= '0; w_cnt <= 0;
    end else if (w_div_start) begin
      w_dbusy    <= 1'b1;
      w_cnt      <= 1;
      w_div_done <= 1'b0;
      w_div_rem  <= w_div_dividend % w_div_divisor;
    end else if (w_dbusy) begin
      if (w_cnt == 0) begin w_dbusy <= 1'b0; w_div_done <= 1'b1; end
      else w_cnt <= w_cnt - 1;
    end else begin
      w_div_done <= 1'b0;
    end
  end

  // ---------------- reference model ----------------
  // Right-to-left binary exponentiation; 1 mod N seeds the result so that
  // exp==0 gives 1 mod N and N==1 gives 0.
  function automatic logic [BW-1:0] ref_pow(input logic [BW-1:0] b,
                                            input logic [BW-1:0] e,
                                            input logic [BW-1:0] n,
                                            input int ebits);
    logic [2*BW-1:0] r, x, nn;
    if (n == '0) return '0;
    nn = {{BW{1'b0}}, n};
    r  = {{(2*BW-1){1'b0}}, 1'b1} % nn;
    x  = {{BW{1'b0}}, b} % nn;
    for (int i = 0; i < ebits; i++) begin
      if (e[i]) r = (r * x) % nn;
      x = (x * x) % nn;
    end
    return r[BW-1:0];
  endfunction

  // Drive one request starting now (caller sits just after a clock edge) and
  // wait for done. inj_at >= 0 pulses a bogus start that many cycles in.
  task automatic run_op(input logic [W-1:0] b, input logic [EW-1:0] e,
                        input logic [W-1:0] n, input int inj_at,
                        output int cyc, output int launches, output bit acc);
    int s0;
    start = 1'b1; base = b; exp = e; modulus = n; s0 = n_starts;
    @(posedge clk); #1;
    start = 1'b0; base = W'($urandom); exp = EW'($urandom); modulus = W'($urandom);
    acc = busy;
    cyc = 0;
    while (!done && cyc < 5000) begin
      if (cyc == inj_at) begin
        start = 1'b1; base = W'($urandom); exp = EW'($urandom); modulus = W'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    launches = n_starts - s0;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL timeout got done=%0b want done=1 after %0d cycles", done, cyc);
    end
  endtask

  task automatic test_reset;
    start = 1'b0; base = '0; exp = '0; modulus = '0;
    w_start = 1'b0; w_base = '0; w_exp = '0; w_mod = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err, div_start} !== 4'b0 || result !== '0 ||
        mul_a !== '0 || mul_b !== '0 || div_dividend !== '0 || div_divisor !== '0) begin
      failures++;
      $display("FAIL reset_hold got busy=%0b done=%0b err=%0b res=%0d want all 0",
               busy, done, err, result);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, err, div_start} !== 4'b0 || result !== '0) begin
      failures++;
      $display("FAIL reset_release got busy=%0b done=%0b err=%0b res=%0d want 0",
               busy, done, err, result);
    end
  endtask

  task automatic test_known;
    int cyc, l; bit a;
    run_op(16'd4, 16'd13, 16'd497, -1, cyc, l, a);
    checks++;
    if (a !== 1'b1) begin failures++; $display("FAIL busy_after_start got %0b want 1", a); end
    checks++;
    if (result !== 16'd445 || err !== 1'b0) begin
      failures++; $display("FAIL pow_4_13 got res=%0d err=%0b want 445 err=0", result, err);
    end
    checks++;
    if (l != 20) begin failures++; $display("FAIL launches_4_13 got %0d want 20", l); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 16'd445) begin
      failures++;
      $display("FAIL done_one_cycle got done=%0b busy=%0b res=%0d want 0 0 445", done, busy, result);
    end
    run_op(16'd600, 16'd1, 16'd497, -1, cyc, l, a);
    checks++;
    if (result !== 16'd103) begin failures++; $display("FAIL prereduce got %0d want 103", result); end
    @(posedge clk); #1;
    run_op(16'd600, 16'd0, 16'd497, -1, cyc, l, a);
    checks++;
    if (result !== 16'd1) begin failures++; $display("FAIL exp_zero got %0d want 1", result); end
    @(posedge clk); #1;
    run_op(16'd5, 16'd7, 16'd1, -1, cyc, l, a);
    checks++;
    if (result !== 16'd0) begin failures++; $display("FAIL mod_one got %0d want 0", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_mod;
    int cyc, l; bit a;
    run_op(16'd9, 16'd5, 16'd0, -1, cyc, l, a);
    checks++;
    if (err !== 1'b1 || result !== '0 || l != 0 || cyc + 1 > 3) begin
      failures++;
      $display("FAIL zero_mod got err=%0b res=%0d launches=%0d cyc=%0d want 1 0 0 <=3",
               err, result, l, cyc + 1);
    end
    @(posedge clk); #1;
    run_op(16'd4, 16'd13, 16'd497, -1, cyc, l, a);
    checks++;
    if (err !== 1'b0 || result !== 16'd445) begin
      failures++; $display("FAIL err_clear got err=%0b res=%0d want 0 445", err, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int cyc, l; bit a;
    logic [W-1:0] b, n; logic [EW-1:0] e; logic [BW-1:0] r;
    for (int i = 0; i < 6; i++) begin
      b = W'($urandom); e = EW'($urandom); n = W'($urandom_range(2, 65535));
      hold_done = 1'($urandom_range(0, 1));
      r = ref_pow(BW'(b), BW'(e), BW'(n), EW);
      run_op(b, e, n, -1, cyc, l, a);
      checks++;
      if (result !== r[W-1:0] || l != 1 + EW + $countones(e)) begin
        failures++;
        $display("FAIL random_%0d b=%0d e=%0d n=%0d got res=%0d launches=%0d want %0d %0d",
                 i, b, e, n, result, l, r[W-1:0], 1 + EW + $countones(e));
      end
      @(posedge clk); #1;
    end
    hold_done = 1'b0;
  endtask

  task automatic test_back_to_back;
    int cyc, l, se; bit a;
    hold_done = 1'b1;
    se = stable_err;
    run_op(16'd4, 16'd13, 16'd497, 50, cyc, l, a);
    checks++;
    if (result !== 16'd445 || l != 20) begin
      failures++;
      $display("FAIL held_done_midstart got res=%0d launches=%0d want 445 20", result, l);
    end
    checks++;
    if (stable_err != se) begin
      failures++; $display("FAIL operand_stable got %0d changes want 0", stable_err - se);
    end
    // start presented in the done cycle is ignored; one cycle later it is taken
    start = 1'b1; base = 16'd5; exp = 16'd3; modulus = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL start_in_done got busy=%0b want 0", busy); end
    run_op(16'd5, 16'd3, 16'd7, -1, cyc, l, a);
    checks++;
    if (a !== 1'b1 || result !== 16'd6) begin
      failures++; $display("FAIL start_after_done got busy=%0b res=%0d want 1 6", a, result);
    end
    hold_done = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int cyc, l, k; bit a;
    start = 1'b1; base = 16'd4; exp = 16'd13; modulus = 16'd497;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!div_start && k < 100) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;      // now waiting on the divider
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, div_start} !== 4'b0 || result !== '0 || mul_a !== '0 ||
        mul_b !== '0 || div_dividend !== '0 || div_divisor !== '0 || k >= 100) begin
      failures++;
      $display("FAIL async_reset got busy=%0b done=%0b res=%0d dvd=%0d k=%0d want all 0",
               busy, done, result, div_dividend, k);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL no_done_after_reset got done=%0b busy=%0b want 0 0", done, busy);
    end
    run_op(16'd4, 16'd13, 16'd497, -1, cyc, l, a);
    checks++;
    if (result !== 16'd445) begin failures++; $display("FAIL rerun_after_reset got %0d want 445", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_wide;
    int cyc;
    logic [BW-1:0] r;
    w_base = BW'(2); w_exp = BW'(65537);
    for (int i = 0; i < BW / 32; i++) w_mod[i*32 +: 32] = $urandom;
    w_mod[BW-1] = 1'b1; w_mod[0] = 1'b1;
    r = ref_pow(w_base, w_exp, w_mod, BW);
    w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    cyc = 0;
    while (!w_done && cyc < 30000) begin @(posedge clk); #1; cyc++; end
    checks++;
    if (w_done !== 1'b1 || w_err !== 1'b0 || w_result !== r) begin
      failures++;
      $display("FAIL wide_pow got done=%0b err=%0b res_lo=%0h want res_lo=%0h",
               w_done, w_err, w_result[63:0], r[63:0]);
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_zero_mod();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
